// File: rtl/div_iter_core_pkg.sv
// Shared helpers for the iterative unsigned divider.
// Holds only width-independent decision logic; no types are declared here.
package div_iter_core_pkg;

  // Early exit when the divisor is zero or is already wider than the dividend.
  // In both cases the quotient is known without iterating.
  function automatic logic take_early_path(
    input logic        divisor_is_zero,
    input int unsigned divisor_clz,
    input int unsigned dividend_clz
  );
    return divisor_is_zero || (divisor_clz < dividend_clz);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Iterative restoring unsigned divider: one quotient bit per cycle.
// Operands are pre-aligned using upstream leading-zero counts.
module div_iter_core
  import div_iter_core_pkg::*;
#(
  parameter  int DIV_WIDTH = 32,
  localparam int CLZ_WIDTH = $clog2(DIV_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic [CLZ_WIDTH-1:0] dividend_CLZ,
  input  logic [CLZ_WIDTH-1:0] divisor_CLZ,
  input  logic                 divisor_is_zero,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FINISH
  } state_t;

  state_t                 state_q;
  state_t                 state_d;
  logic [CLZ_WIDTH-1:0]   count_q;
  logic [CLZ_WIDTH-1:0]   shift;
  logic [DIV_WIDTH-1:0]   rem_q;
  logic [DIV_WIDTH-1:0]   quo_q;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [DIV_WIDTH:0]     diff;
  logic                   accept;
  logic                   early;
  logic                   ge;

  // A start while BUSY is a protocol violation and is silently ignored.
  assign accept = start && (state_q != BUSY);
  assign early  = take_early_path(divisor_is_zero, 32'(divisor_CLZ), 32'(dividend_CLZ));
  assign shift  = divisor_CLZ - dividend_CLZ;

  // The extra top bit acts as the borrow: clear means remainder >= divisor.
  assign diff = {1'b0, rem_q} - {1'b0, div_q};
  assign ge   = ~diff[DIV_WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, FINISH: begin
        if (start) state_d = early ? FINISH : BUSY;
        else       state_d = IDLE;
      end
      BUSY: begin
        if (count_q == '0) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !early) begin
        count_q <= shift;
      end else if (state_q == BUSY && count_q != '0) begin
        count_q <= count_q - CLZ_WIDTH'(1);
      end
    end
  end

  // NOTE: the datapath registers carry no reset; results are only meaningful
  // after done, so resetting them would cost fan-out for no behavioural gain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        rem_q <= dividend;
        quo_q <= (early && divisor_is_zero) ? '1 : '0;
        div_q <= divisor << shift;
      end else if (state_q == BUSY) begin
        if (ge) rem_q <= diff[DIV_WIDTH-1:0];
        quo_q <= {quo_q[DIV_WIDTH-2:0], ge};
        div_q <= div_q >> 1;
      end
    end
  end

  assign done      = (state_q == FINISH);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_div_iter_core.sv
// Scoreboard bench for div_iter_core: stimulus pushes expected results from an
// arithmetic model; a negedge monitor pops and compares on every done pulse.
module tb_div_iter_core;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           start_cyc;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [4:0]   dividend_clz;
  logic [4:0]   divisor_clz;
  logic         divisor_is_zero;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;

  div_iter_core #(.DIV_WIDTH(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .dividend        (dividend),
    .divisor         (divisor),
    .dividend_CLZ    (dividend_clz),
    .divisor_CLZ     (divisor_clz),
    .divisor_is_zero (divisor_is_zero),
    .done            (done),
    .quotient        (quotient),
    .remainder       (remainder)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int clz32(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return W - 1 - i;
    return W;
  endfunction

  // Drives one start cycle; when track is set, queues the model's answer.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    exp_t e;
    int   ca;
    int   cb;
    ca = clz32(a);
    cb = (b == 0) ? 0 : clz32(b);
    dividend        = a;
    divisor         = b;
    dividend_clz    = 5'(ca);
    divisor_clz     = 5'(cb);
    divisor_is_zero = (b == 0);
    start           = 1'b1;
    if (track) begin
      if (b == 0) begin
        e.q = '1; e.r = a; e.lat = 1;
      end else begin
        e.q = a / b; e.r = a % b;
        e.lat = (cb < ca) ? 1 : (cb - ca + 2);
      end
      e.start_cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start           = 1'b0;
    dividend        = $urandom;
    divisor         = $urandom;
    dividend_clz    = 5'($urandom);
    divisor_clz     = 5'($urandom);
    divisor_is_zero = 1'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_timeout"}, 64'(sb.size()), 64'd0);
      sb.delete();
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
      end
    end
  end

  initial begin
    int           dc;
    int           n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    dividend_clz = '0; divisor_clz = '0; divisor_is_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done_low", 64'(done), 64'd0);
    rst = 1'b0;

    issue(32'd100, 32'd7, 1'b1);          wait_drain("div_100_7");
    issue(32'd5, 32'd9, 1'b1);            wait_drain("div_5_9");
    issue(32'h1234, 32'd0, 1'b1);         wait_drain("div_by_zero");
    issue(32'hFFFF_FFFF, 32'd1, 1'b1);    wait_drain("div_max_1");

    // Back-to-back: next start lands in the done cycle of the previous one.
    issue(32'd100, 32'd7, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    check("b2b_done_seen", 64'(done), 64'd1);
    check("b2b_q_visible", 64'(quotient), 64'd14);
    issue(32'd81, 32'd9, 1'b1);
    wait_drain("b2b_81_9");

    // A stray start while busy must not disturb the running division.
    issue(32'd1000000, 32'd3, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    issue(32'd7, 32'd1, 1'b0);
    wait_drain("start_while_busy");

    // Reset in cycle 3 of a long division abandons it without done.
    issue(32'hFFFF_FFFF, 32'd1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dc = done_count;
    repeat (40) @(posedge clk);
    #1;
    check("no_done_after_rst", 64'(done_count), 64'(dc));
    issue(32'd100, 32'd7, 1'b1);          wait_drain("after_rst_100_7");

    // Start coincident with reset is dropped.
    rst = 1'b1;
    dc = done_count;
    issue(32'd100, 32'd7, 1'b0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("start_with_rst_dropped", 64'(done_count), 64'(dc));

    for (int i = 0; i < 40; i++) begin
      a = $urandom >> $urandom_range(0, 31);
      if (a == 0) a = 1;
      b = ($urandom_range(0, 9) == 0) ? '0 : ($urandom >> $urandom_range(0, 31));
      issue(a, b, 1'b1);
      wait_drain("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
